// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing, frame geometry and receiver state encoding.
package uart_pkg;

    localparam logic [11:0] BAUD_TIME = 12'hA2C;  // 50 MHz / 19200 baud
    localparam int          DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: serial line in, byte/flag handshake out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx;
    logic                 clr_rdy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_rdy;
    logic                 frm_err;
    logic                 ovr_err;

    modport master (output rx, clr_rdy, input rx_data, rx_rdy, frm_err, ovr_err);
    modport slave  (input rx, clr_rdy, output rx_data, rx_rdy, frm_err, ovr_err);

endinterface

// File: rtl/uart_baud_cnt.sv
// Free-running baud counter with half-bit and full-bit strobes; wraps on its own at full_bd.
module uart_baud_cnt #(
    parameter int BAUD_TIME = int'(uart_pkg::BAUD_TIME)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic half_bd,
    output logic full_bd
);

    localparam int HALF_BAUD = BAUD_TIME / 2;

    logic [11:0] cnt;

    assign half_bd = (cnt == 12'(HALF_BAUD - 1));
    assign full_bd = (cnt == 12'(BAUD_TIME - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || full_bd) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 12'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, start-bit validation, mid-bit sampling and sticky error flags.
module uart_rx #(
    parameter int BAUD_TIME = int'(uart_pkg::BAUD_TIME)
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);
    import uart_pkg::*;

    logic                 rx_meta_p0, rx_s_p1, rx_prev_p2;
    logic                 fall;
    logic                 baud_clr, half_bd, full_bd;
    rx_state_t            state;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rdy_q, frm_q, ovr_q;

    // Synchronizer stage: preset high so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_s_p1    <= 1'b1;
            rx_prev_p2 <= 1'b1;
        end else begin
            rx_meta_p0 <= bus.rx;
            rx_s_p1    <= rx_meta_p0;
            rx_prev_p2 <= rx_s_p1;
        end
    end

    assign fall     = rx_prev_p2 & ~rx_s_p1;
    assign baud_clr = (state == IDLE) || (state == START && half_bd);

    uart_baud_cnt #(.BAUD_TIME(BAUD_TIME)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (baud_clr),
        .half_bd (half_bd),
        .full_bd (full_bd)
    );

    // Sampling stage: every data bit is fully overwritten before use, so no reset
    always_ff @(posedge clk) begin
        if (state == DATA && full_bd) begin
            shreg <= {rx_s_p1, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            frm_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (bus.clr_rdy && rdy_q) begin
                rdy_q <= 1'b0;
                frm_q <= 1'b0;
                ovr_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fall) state <= START;
                end
                START: begin
                    if (half_bd) begin
                        if (rx_s_p1) begin
                            state <= IDLE;
                        end else begin
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (full_bd) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'(DATA_BITS - 1)) state <= STOP;
                    end
                end
                STOP: begin
                    // Completion overrides a same-cycle clear; that clear also suppresses overrun
                    if (full_bd) begin
                        bit_cnt   <= bit_cnt + 4'd1;
                        rx_data_q <= shreg;
                        rdy_q     <= 1'b1;
                        frm_q     <= ~rx_s_p1;
                        ovr_q     <= ~bus.clr_rdy & (ovr_q | rdy_q);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rx_data = rx_data_q;
    assign bus.rx_rdy  = rdy_q;
    assign bus.frm_err = frm_q;
    assign bus.ovr_err = ovr_q;

endmodule
